// File: rtl/time_surface_scanner_pkg.sv
// Shared types and default dimensions for the time-surface read-side scanner.
package time_surface_pkg;

  localparam int GRID_SIZE_DEF    = 32;
  localparam int NUM_CELLS        = GRID_SIZE_DEF * GRID_SIZE_DEF;
  localparam int ADDR_BITS_DEF    = 10;
  localparam int VALUE_BITS_DEF   = 8;
  localparam int READ_LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  // One buffered feature beat: surface value, its cell index, end-of-frame flag.
  typedef struct packed {
    logic [VALUE_BITS_DEF-1:0] value;
    logic [ADDR_BITS_DEF-1:0]  addr;
    logic                      last;
  } feat_beat_t;

endpackage

// File: rtl/time_surface_scanner_if.sv
// Valid/ready feature stream from the scanner to the classifier front end.
interface time_surface_scanner_if
  import time_surface_pkg::*;
#(
  parameter int VALUE_BITS = VALUE_BITS_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
);
  logic                  feat_valid;
  logic                  feat_ready;
  logic [VALUE_BITS-1:0] feat_data;
  logic [ADDR_BITS-1:0]  feat_addr;
  logic                  feat_last;

  modport master (output feat_valid, feat_data, feat_addr, feat_last, input feat_ready);
  modport slave  (input feat_valid, feat_data, feat_addr, feat_last, output feat_ready);
endinterface

// File: rtl/time_surface_scanner_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Head data reads as zero while empty so the stream outputs are clean after reset.
module ts_scan_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign do_wr   = wr_en && (count_q != CNT_W'(DEPTH));
  assign do_rd   = rd_en && (count_q != '0);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer wrap and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (do_wr && !do_rd)      count_d = count_q + 1'b1;
    else if (!do_wr && do_rd) count_d = count_q - 1'b1;
  end

  // Control state; cleared by reset so the FIFO starts empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/time_surface_scanner.sv
// Raster-order read master for the time-surface store. Reads are only issued
// while buffered plus in-flight beats leave room in the output FIFO, so no
// returned value is ever dropped under backpressure.
module time_surface_scanner
  import time_surface_pkg::*;
#(
  parameter int GRID_SIZE     = GRID_SIZE_DEF,
  parameter int ADDR_BITS     = ADDR_BITS_DEF,
  parameter int VALUE_BITS    = VALUE_BITS_DEF,
  parameter int READ_LATENCY  = READ_LATENCY_DEF,
  parameter int FIFO_DEPTH    = 4,
  parameter int ACTIVE_THRESH = 128
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            scan_start,
  output logic                            scan_busy,
  output logic                            scan_done,
  output logic                            read_enable,
  output logic [ADDR_BITS-1:0]            read_addr,
  input  logic [VALUE_BITS-1:0]           read_value,
  time_surface_scanner_if.master          feat,
  output logic [VALUE_BITS+ADDR_BITS-1:0] frame_sum,
  output logic [VALUE_BITS-1:0]           frame_max,
  output logic [ADDR_BITS:0]              frame_active
);
  localparam int CELLS = GRID_SIZE * GRID_SIZE;
  localparam int SUM_W = VALUE_BITS + ADDR_BITS;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(READ_LATENCY + 1);
  localparam logic [ADDR_BITS-1:0]  LAST_ADDR = ADDR_BITS'(CELLS - 1);
  localparam logic [VALUE_BITS-1:0] THRESH    = VALUE_BITS'(ACTIVE_THRESH);

  scan_state_t             state_q, state_d;
  logic [ADDR_BITS-1:0]    cnt_q, cnt_d;
  logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [ADDR_BITS-1:0]    tag_addr_q [READ_LATENCY];
  logic [ADDR_BITS-1:0]    tag_addr_d [READ_LATENCY];
  logic [SUM_W-1:0]        sum_q, sum_d, fsum_q, fsum_d;
  logic [VALUE_BITS-1:0]   max_q, max_d, fmax_q, fmax_d;
  logic [ADDR_BITS:0]      act_q, act_d, fact_q, fact_d;

  logic [CNT_W-1:0]     fifo_count;
  logic [INF_W-1:0]     inflight;
  logic                 fifo_empty, issue, ret, pop;
  logic [ADDR_BITS-1:0] ret_addr;
  feat_beat_t           wr_beat, rd_beat;

  assign ret      = tag_vld_q[READ_LATENCY-1];
  assign ret_addr = tag_addr_q[READ_LATENCY-1];
  assign issue    = (state_q == SCAN) &&
                    ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH));

  assign wr_beat.value = read_value;
  assign wr_beat.addr  = ret_addr;
  assign wr_beat.last  = (ret_addr == LAST_ADDR);

  ts_scan_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(feat_beat_t)),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ret),
    .wr_data (wr_beat),
    .rd_en   (pop),
    .rd_data (rd_beat),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign feat.feat_valid = !fifo_empty;
  assign feat.feat_data  = rd_beat.value;
  assign feat.feat_addr  = rd_beat.addr;
  assign feat.feat_last  = rd_beat.last;
  assign pop             = !fifo_empty && feat.feat_ready;

  // Store pipeline keeps advancing through SCAN and DRAIN; idle cycles hold the address.
  assign read_enable  = (state_q == SCAN) || (state_q == DRAIN);
  assign read_addr    = cnt_q;
  assign scan_busy    = (state_q == SCAN) || (state_q == DRAIN);
  assign scan_done    = (state_q == DONE);
  assign frame_sum    = fsum_q;
  assign frame_max    = fmax_q;
  assign frame_active = fact_q;

  // Count issued reads still travelling through the store.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + INF_W'(tag_vld_q[i]);
  end

  // Tag shift register mirrors the store latency; only issued slots carry data.
  always_comb begin
    tag_vld_d[0]  = issue;
    tag_addr_d[0] = cnt_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_addr_d[i] = tag_addr_q[i-1];
    end
  end

  // Sweep control and per-frame statistics.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    max_d   = max_q;
    act_d   = act_q;
    fsum_d  = fsum_q;
    fmax_d  = fmax_q;
    fact_d  = fact_q;
    if (ret) begin
      sum_d = sum_q + SUM_W'(read_value);
      if (read_value > max_q) max_d = read_value;
      if (read_value >= THRESH) act_d = act_q + 1'b1;
    end
    case (state_q)
      IDLE: if (scan_start) begin
        state_d = SCAN;
        cnt_d   = '0;
        sum_d   = '0;
        max_d   = '0;
        act_d   = '0;
      end
      // The final cell is detected by compare; the counter parks on it for DRAIN.
      SCAN: if (issue) begin
        if (cnt_q == LAST_ADDR) state_d = DRAIN;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      // With nothing in flight and the FIFO empty the accumulators are final.
      DRAIN: if ((inflight == '0) && fifo_empty) begin
        state_d = DONE;
        fsum_d  = sum_q;
        fmax_d  = max_q;
        fact_d  = act_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // All scanner state; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_addr_q[i] <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      act_q     <= '0;
      fsum_q    <= '0;
      fmax_q    <= '0;
      fact_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_vld_q  <= tag_vld_d;
      tag_addr_q <= tag_addr_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      act_q      <= act_d;
      fsum_q     <= fsum_d;
      fmax_q     <= fmax_d;
      fact_q     <= fact_d;
    end
  end

endmodule

// File: tb/tb_time_surface_scanner.sv
// Scoreboard bench: stimulus queues expected beats and frame statistics,
// a negedge monitor pops and compares whenever the DUT hands over a beat or scan_done.
module tb_time_surface_scanner;
  import time_surface_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_start = 1'b0;
  logic        scan_busy, scan_done, read_enable;
  logic [9:0]  read_addr;
  logic [7:0]  read_value;
  logic [17:0] frame_sum;
  logic [7:0]  frame_max;
  logic [10:0] frame_active;

  time_surface_scanner_if fif ();

  time_surface_scanner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_start   (scan_start),
    .scan_busy    (scan_busy),
    .scan_done    (scan_done),
    .read_enable  (read_enable),
    .read_addr    (read_addr),
    .read_value   (read_value),
    .feat         (fif),
    .frame_sum    (frame_sum),
    .frame_max    (frame_max),
    .frame_active (frame_active)
  );

  always #5 clk = ~clk;

  // Store stub: value is the low byte of the address, two cycles later.
  logic [9:0] s1, s2;
  logic       zero_store = 1'b0;
  always @(posedge clk) begin
    s1 <= read_addr;
    s2 <= s1;
  end
  assign read_value = zero_store ? 8'd0 : s2[7:0];

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] addr;
    logic       last;
  } beat_t;

  typedef struct {
    logic [17:0] sum;
    logic [7:0]  max;
    logic [10:0] act;
  } stats_t;

  beat_t  exp_q[$];
  stats_t st_q[$];
  int     tests = 0;
  int     fails = 0;
  int     done_cnt = 0;
  int     beats_seen = 0;
  int     rdy_mode = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic push_frame(input bit zero);
    stats_t s;
    for (int i = 0; i < 1024; i++) begin
      beat_t b;
      b.data = zero ? 8'd0 : 8'(i);
      b.addr = 10'(i);
      b.last = (i == 1023);
      exp_q.push_back(b);
    end
    s.sum = zero ? 18'd0 : 18'd130560;
    s.max = zero ? 8'd0  : 8'd255;
    s.act = zero ? 11'd0 : 11'd512;
    st_q.push_back(s);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 scan_start = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    repeat (5) @(posedge clk);
    chk({nm, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  // Downstream ready pattern: always, stalled, or random 50%.
  initial begin
    fif.feat_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       fif.feat_ready = 1'b1;
        1:       fif.feat_ready = 1'b0;
        default: fif.feat_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: beat handshakes, stall stability, end-of-frame statistics.
  initial begin
    beat_t  cur, held, e;
    stats_t s;
    bit     hold_pend;
    hold_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        cur = {fif.feat_data, fif.feat_addr, fif.feat_last};
        if (hold_pend) chk("stall_hold", 32'({fif.feat_valid, cur}), 32'({1'b1, held}));
        if (fif.feat_valid && fif.feat_ready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got addr %0d want none", fif.feat_addr);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 32'(cur), 32'(e));
          end
        end
        hold_pend = fif.feat_valid && !fif.feat_ready;
        held = cur;
        if (scan_done) begin
          done_cnt++;
          chk("done_after_last_beat", 32'(exp_q.size()), 32'd0);
          if (st_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got scan_done want none");
          end else begin
            s = st_q.pop_front();
            chk("frame_sum", 32'(frame_sum), 32'(s.sum));
            chk("frame_max", 32'(frame_max), 32'(s.max));
            chk("frame_active", 32'(frame_active), 32'(s.act));
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int n;
    int base;
    int d0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(fif.feat_valid), 32'd0);
    chk("rst_busy", 32'(scan_busy), 32'd0);
    chk("rst_done", 32'(scan_done), 32'd0);
    chk("rst_rden", 32'(read_enable), 32'd0);
    chk("rst_sum", 32'(frame_sum), 32'd0);
    rst_n = 1'b1;

    // Full frame with ready held high; first beat latency.
    push_frame(1'b0);
    pulse_start();
    chk("busy_in_scan", 32'(scan_busy), 32'd1);
    n = 1;
    while (!fif.feat_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_valid_cycle", 32'(n), 32'd4);
    wait_done("s1");

    // Twenty-cycle stall mid-frame; issued reads must stop at FIFO depth.
    base = beats_seen;
    push_frame(1'b0);
    pulse_start();
    repeat (200) @(posedge clk);
    rdy_mode = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("stall_credit", 32'(read_addr), 32'(beats_seen - base + 4));
    rdy_mode = 0;
    wait_done("s2");

    // Random backpressure.
    rdy_mode = 2;
    push_frame(1'b0);
    pulse_start();
    wait_done("s3");
    rdy_mode = 0;

    // All-zero store.
    zero_store = 1'b1;
    push_frame(1'b1);
    pulse_start();
    wait_done("s4");
    zero_store = 1'b0;

    // Starts during SCAN and in the DONE cycle are ignored.
    d0 = done_cnt;
    push_frame(1'b0);
    pulse_start();
    repeat (100) @(posedge clk);
    #1 scan_start = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0;
    n = 0;
    while (!scan_done && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s5_done_seen", 32'(scan_done), 32'd1);
    scan_start = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("s5_idle_after_done_start", 32'(scan_busy), 32'd0);
    chk("s5_one_done", 32'(done_cnt - d0), 32'd1);

    // Reset at beat 300 aborts the frame.
    base = beats_seen;
    push_frame(1'b0);
    pulse_start();
    n = 0;
    while ((beats_seen - base) < 300 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("s6_reached_300", 32'(beats_seen - base >= 300), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_valid", 32'(fif.feat_valid), 32'd0);
    chk("s6_busy", 32'(scan_busy), 32'd0);
    chk("s6_done", 32'(scan_done), 32'd0);
    chk("s6_rden", 32'(read_enable), 32'd0);
    chk("s6_raddr", 32'(read_addr), 32'd0);
    chk("s6_sum", 32'(frame_sum), 32'd0);
    chk("s6_max", 32'(frame_max), 32'd0);
    chk("s6_active", 32'(frame_active), 32'd0);
    exp_q.delete();
    st_q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("s6_no_done", 32'(done_cnt - d0), 32'd0);
    push_frame(1'b0);
    pulse_start();
    wait_done("s6b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/time_surface_scanner.md
Name: time_surface_scanner

Overview:
Read-side master for the time-surface store. On a start pulse it sweeps every grid cell in raster order over the store's fixed-latency read port and collects the decayed surface values. It streams them out as a valid/ready feature stream for the classifier front end, and reports per-frame statistics (sum, max, active-cell count). A credit scheme guarantees no returned value is lost under downstream backpressure.

Parameters:
GRID_SIZE, 32, grid dimension; NUM_CELLS = GRID_SIZE*GRID_SIZE
ADDR_BITS, 10, log2(NUM_CELLS)
VALUE_BITS, 8, surface value width
READ_LATENCY, 2, cycles from read_enable+read_addr to read_value valid
FIFO_DEPTH, 4, output buffer entries; must be >= READ_LATENCY+1
ACTIVE_THRESH, 128, cell counts as active when value >= this

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
scan_start  in  1  one-cycle start request
scan_busy  out  1  high from accepted start until scan_done
scan_done  out  1  one-cycle pulse at end of frame
read_enable  out  1  store read enable
read_addr  out  ADDR_BITS  store cell address
read_value  in  VALUE_BITS  decayed value, READ_LATENCY cycles after issue
feat_valid  out  1  feature beat valid
feat_ready  in  1  downstream accept
feat_data  out  VALUE_BITS  cell value
feat_addr  out  ADDR_BITS  cell index of feat_data
feat_last  out  1  marks cell NUM_CELLS-1
frame_sum  out  VALUE_BITS+ADDR_BITS  sum of all values of last frame
frame_max  out  VALUE_BITS  max value of last frame
frame_active  out  ADDR_BITS+1  count of cells >= ACTIVE_THRESH

Behaviour:
- Reset: clk and rst_n only; asynchronous, active-low. All outputs 0, FSM IDLE, FIFO empty, tag pipe cleared. Reset mid-scan aborts the frame; no scan_done is issued.
- FSM states and transitions:
  - IDLE: scan_start -> SCAN, address counter = 0, accumulators cleared.
  - SCAN: issue a read when fifo_count + inflight < FIFO_DEPTH. Issue presents read_addr = counter, then increments the counter. After issuing NUM_CELLS-1 -> DRAIN.
  - DRAIN: wait until inflight == 0 and the FIFO is empty -> DONE.
  - DONE: one cycle. scan_done = 1, frame_* registers updated from accumulators -> IDLE.
- read_enable = 1 throughout SCAN and DRAIN, so the store pipeline keeps advancing. Cycles with no issue hold read_addr; their returns are discarded.
- Tag pipeline: a READ_LATENCY-deep shift register of {issued bit, addr}. When the issued bit emerges, read_value and its addr are written to the FIFO. The stats accumulators update on the same cycle.
- inflight = popcount of issued bits in the tag pipe.
- Output:
  - feat_valid = FIFO not empty; a beat transfers when feat_valid & feat_ready.
  - feat_data, feat_addr and feat_last remain stable while valid && !ready.
  - The FIFO never overflows; the credit rule guarantees space.
- Latency: scan_start at cycle 0 -> first issue at cycle 1 -> FIFO write at cycle 1+READ_LATENCY -> feat_valid at cycle 2+READ_LATENCY (4 by default).
- Throughput: 1 beat/cycle with feat_ready held high.
- scan_start while scan_busy is ignored. Back-to-back start in the DONE cycle is ignored; start is accepted in IDLE only.
- Statistics:
  - frame_sum is an unsigned accumulation with no saturation; the width suffices for NUM_CELLS*(2^VALUE_BITS-1).
  - frame_max uses unsigned compare.
  - frame_active increments when value >= ACTIVE_THRESH.
  - frame_* hold the previous frame's result until the next DONE.
- Address counter width is ADDR_BITS. The final cell is flagged by an is_last compare, never by counter wrap.

Decomposition:
- Package time_surface_pkg: NUM_CELLS, READ_LATENCY default, state enum (IDLE, SCAN, DRAIN, DONE), and the feature-beat struct {value, addr, last}.
- One sub-module, ts_scan_fifo: synchronous FIFO with parameterised depth and width, count output, first-word-fall-through.
- Scanner top: FSM, credit/issue logic, tag pipe, statistics.

Test Plan:
- Store stub returns addr[7:0] after 2 cycles; pulse start with feat_ready = 1.
  - First feat_valid at cycle 4; 1024 beats in order with feat_addr = 0..1023; feat_last only on 1023.
  - scan_done pulses once; frame_sum = 130560, frame_max = 255, frame_active = 512.
- Same stub; feat_ready low for 20 cycles mid-frame.
  - Never more than 4 beats outstanding or buffered; no lost or duplicated addr.
  - Data is stable while stalled; the totals match the previous scenario.
- feat_ready randomly toggled at 50% duty: the stream content is identical to the first scenario and scan_done follows the last handshake.
- All-zero store: frame_sum = 0, frame_max = 0, frame_active = 0; scan_done is still pulsed.
- scan_start pulsed during SCAN and in the DONE cycle: ignored, exactly one frame of 1024 beats.
- rst_n asserted at beat 300:
  - All outputs go 0 immediately with no scan_done, and frame_* read 0.
  - A new start yields a clean full frame beginning at addr 0.
